dat_mem_burst_rd: RTL
=====================

DAT_MEM_BURST_RD -- requirements
Module: dat_mem_burst_rd

Interface
REQ-001 Parameter DATA_W, default `Tout, beat data width.
REQ-002 Parameter LEN, default `AXI_BURST_LEN, buffer depth in beats.
REQ-003 Parameter AW, default `log2AXI_BURST_LEN, buffer address width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  burst request pulse; sampled only in IDLE.
REQ-007 start_len  in  AW  beats minus one (AXI LEN style), sampled with start.
REQ-008 busy  out  1  high whenever state is not IDLE.
REQ-009 done  out  1  one-cycle pulse on burst completion.
REQ-010 mem_rd_en  out  1  read enable to burst data buffer.
REQ-011 mem_raddr  out  AW  read address to burst data buffer.
REQ-012 mem_rdata  in  DATA_W  buffer read data, valid one cycle after mem_rd_en, held until next mem_rd_en.
REQ-013 m_wdata  out  DATA_W  AXI write-data beat.
REQ-014 m_wvalid  out  1  AXI write-data valid.
REQ-015 m_wlast  out  1  AXI last beat of burst.
REQ-016 m_wready  in  1  AXI write-data ready from slave.

Function
REQ-017 States: IDLE, RUN; IDLE->RUN on start=1 in IDLE; RUN->IDLE on handshake (m_wvalid&m_wready) with m_wlast=1.
REQ-018 start while busy=1 shall be ignored; start_len is latched only on an accepted start.
REQ-019 Burst length N = start_len+1, range 1..LEN; addresses read are 0..N-1, in order, each exactly once.
REQ-020 Internal 2-entry output buffer; m_wdata/m_wvalid/m_wlast driven from buffer head, registered.
REQ-021 Read issue rule: mem_rd_en=1 iff in RUN, reads issued < N, and (buffered + in-flight − pop this cycle) < 2.
REQ-022 mem_raddr equals reads-issued count (AW bits, no wrap within a burst); don't-care when mem_rd_en=0.
REQ-023 mem_rdata captured into buffer the cycle after its mem_rd_en.
REQ-024 Timing with m_wready=1: start at cycle 0 -> mem_rd_en cycles 1..N (raddr 0..N-1) -> m_wvalid cycles 2..N+1, one beat/cycle, zero bubbles.
REQ-025 m_wlast=1 exactly on beat N-1 (address N-1) and only while m_wvalid=1.
REQ-026 While m_wvalid=1 and m_wready=0: m_wdata, m_wlast held stable, m_wvalid held high, no more than 2 beats read ahead.
REQ-027 m_wvalid, once asserted, shall not deassert before handshake.
REQ-028 done=1 the cycle after final handshake; busy=0 in that same cycle; start in done cycle is accepted.
REQ-029 N=1: single beat with m_wlast=1 on first beat.
REQ-030 mem_rd_en never asserted in IDLE.

Reset
REQ-031 rst=1 at a rising edge -> next cycle: state IDLE, busy=0, done=0, mem_rd_en=0, mem_raddr=0, m_wvalid=0, m_wlast=0, m_wdata=0, buffer empty, counters 0.
REQ-032 rst mid-burst abandons the burst; no done pulse; following start restarts at address 0.
REQ-033 rst has priority over start in the same cycle.

Verification
REQ-034 mem[i]=0xA0+i, start_len=3, m_wready=1 -> mem_rd_en cycles 1-4 raddr 0-3; beats 0xA0-0xA3 cycles 2-5; m_wlast cycle 5; done cycle 6.
REQ-035 Same burst, m_wready alternating 1,0 from cycle 2 -> 4 handshakes 0xA0-0xA3 in order, m_wdata stable during every stall, single done.
REQ-036 start_len=7, m_wready=0 for 10 cycles -> exactly 2 mem_rd_en (raddr 0,1), m_wvalid held with 0xA0; then m_wready=1 -> 8 beats, no gaps.
REQ-037 start_len=0 -> one beat 0xA0 with m_wlast=1, done next cycle; start_len=LEN-1 with start re-asserted in done cycle -> two back-to-back LEN-beat bursts.
REQ-038 start during RUN -> ignored, beat count unchanged; rst at beat 2 of 4 -> all outputs 0 next cycle, no done; new start_len=1 -> beats 0xA0,0xA1.

Source files
------------

// File: rtl/dat_mem_burst_rd.sv
// dat_mem_burst_rd
// Reads one burst of beats out of a burst data buffer and streams it as AXI
// write-data beats. A burst of N = start_len+1 beats reads buffer addresses
// 0..N-1 in order. Up to two beats are held ahead of the AXI slave, so the
// stream runs without bubbles while m_wready stays high and stalls cleanly
// when it drops.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, start_len      burst request pulse and length minus one (IDLE only)
//   busy, done            burst in progress / one-cycle completion pulse
//   mem_rd_en, mem_raddr  read port to the burst data buffer
//   mem_rdata             buffer read data, valid the cycle after mem_rd_en
//   m_wdata, m_wvalid,    AXI write-data channel towards the slave
//   m_wlast, m_wready

`ifndef Tout
`define Tout 32
`endif
`ifndef AXI_BURST_LEN
`define AXI_BURST_LEN 16
`endif
`ifndef log2AXI_BURST_LEN
`define log2AXI_BURST_LEN 4
`endif

module dat_mem_burst_rd #(
  parameter int DATA_W = `Tout,
  parameter int LEN    = `AXI_BURST_LEN,
  parameter int AW     = `log2AXI_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     start_len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wvalid,
  output logic              m_wlast,
  input  logic              m_wready
);

  // Read counter must reach N (= LEN at most), one bit wider than an address.
  localparam int CW = $clog2(LEN + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_reg;
  logic [AW-1:0]       len_reg;
  logic [CW-1:0]       rd_cnt_reg;
  logic [AW-1:0]       beat_cnt_reg;
  logic                inflight_reg;
  logic [1:0]          cnt_reg;
  logic [DATA_W-1:0]   buf_reg [2];
  logic                done_reg;

  logic                hs;
  logic                pop_buf;
  logic                push;
  logic [2:0]          occ;
  logic [1:0]          cnt_pop;
  logic [1:0]          cnt_next;
  logic [CW-1:0]       len_ext;
  logic [DATA_W-1:0]   head_data;

  // The beat being read this cycle (inflight) sits in the buffer's own output
  // register, which holds it until the next read. It is the youngest entry:
  // it is only the head when the local skid entries are empty. This gives a
  // single cycle from read enable to m_wvalid with every source a flop.
  assign head_data = (cnt_reg != 2'd0) ? buf_reg[0] : mem_rdata;
  assign m_wvalid  = (cnt_reg != 2'd0) || inflight_reg;
  assign m_wdata   = m_wvalid ? head_data : '0;
  assign m_wlast   = m_wvalid && (beat_cnt_reg == len_reg);

  assign hs = m_wvalid && m_wready;

  // A handshake consumes a skid entry if one exists, otherwise the in-flight
  // beat goes straight out and is never written locally.
  assign pop_buf  = hs && (cnt_reg != 2'd0);
  assign push     = inflight_reg && !(hs && (cnt_reg == 2'd0));
  assign cnt_pop  = cnt_reg - {1'b0, pop_buf};
  assign cnt_next = cnt_pop + {1'b0, push};

  // Occupancy counts in-flight data; the pop of this cycle frees a slot in
  // time for the next read, which keeps the stream gap-free.
  assign occ     = {1'b0, cnt_reg} + {2'b00, inflight_reg};
  assign len_ext = {{(CW-AW){1'b0}}, len_reg};

  assign mem_rd_en = (state_reg == RUN) && (rd_cnt_reg <= len_ext) &&
                     (occ < (3'd2 + {2'b00, hs}));
  assign mem_raddr = rd_cnt_reg[AW-1:0];

  assign busy = (state_reg == RUN);
  assign done = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      rd_cnt_reg   <= '0;
      beat_cnt_reg <= '0;
      inflight_reg <= 1'b0;
      cnt_reg      <= 2'd0;
      done_reg     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_reg[i] <= '0;
      end
    end else begin
      done_reg     <= 1'b0;
      inflight_reg <= mem_rd_en;
      cnt_reg      <= cnt_next;

      if (mem_rd_en) begin
        rd_cnt_reg <= rd_cnt_reg + CW'(1);
      end
      if (hs) begin
        beat_cnt_reg <= beat_cnt_reg + AW'(1);
      end

      // Skid entries: shift on pop, then land the in-flight beat behind
      // whatever remains.
      if (pop_buf) begin
        buf_reg[0] <= buf_reg[1];
      end
      if (push) begin
        if (cnt_pop == 2'd0) begin
          buf_reg[0] <= mem_rdata;
        end else begin
          buf_reg[1] <= mem_rdata;
        end
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= RUN;
            len_reg      <= start_len;
            rd_cnt_reg   <= '0;
            beat_cnt_reg <= '0;
          end
        end
        RUN: begin
          if (hs && m_wlast) begin
            state_reg    <= IDLE;
            done_reg     <= 1'b1;
            rd_cnt_reg   <= '0;
            beat_cnt_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
